// File: rtl/branch_resolve_unit_if.sv
// Signal bundle between the ID stage / hazard unit / IF stage and the branch resolve unit.
// The master side drives branch requests and lookups; the slave side is the resolve unit.
interface branch_resolve_unit_if #(
  parameter int WIDTH = 32
);
  logic             br_valid;
  logic [2:0]       br_type;
  logic [31:0]      br_pc;
  logic             br_pred;
  logic [WIDTH-1:0] opnd_a;
  logic [WIDTH-1:0] opnd_b;
  logic             opnd_ready;
  logic             flush;
  logic [31:0]      if_pc;
  logic             pred_taken;
  logic             br_stall;
  logic             res_valid;
  logic             res_taken;
  logic             mispredict;
  logic [31:0]      br_count;
  logic [31:0]      miss_count;

  modport master (
    output br_valid, br_type, br_pc, br_pred, opnd_a, opnd_b, opnd_ready, flush, if_pc,
    input  pred_taken, br_stall, res_valid, res_taken, mispredict, br_count, miss_count
  );

  modport slave (
    input  br_valid, br_type, br_pc, br_pred, opnd_a, opnd_b, opnd_ready, flush, if_pc,
    output pred_taken, br_stall, res_valid, res_taken, mispredict, br_count, miss_count
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// ID-stage branch resolution: evaluates six MIPS branch conditions, stalls until operands are
// final, trains a direct-mapped 2-bit counter table for IF prediction and keeps statistics.
module branch_resolve_unit #(
  parameter int WIDTH     = 32,
  parameter int BHT_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  branch_resolve_unit_if.slave  bus
);
  localparam int IDX = $clog2(BHT_DEPTH);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       type_q, type_d;
  logic [IDX-1:0]   idx_q, idx_d;
  logic             pred_q, pred_d;
  logic             res_valid_q, res_taken_q, mispredict_q;
  logic [31:0]      br_count_q, miss_count_q;
  logic [1:0]       bht_q [BHT_DEPTH];

  logic             resolve;
  logic             stall;
  logic [2:0]       eff_type;
  logic [IDX-1:0]   eff_idx;
  logic             eff_pred;
  logic             taken;
  logic [1:0]       bht_upd;
  logic [IDX-1:0]   lookup_idx;

  // FSM: next state, stall request and latch enables
  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    idx_d   = idx_q;
    pred_d  = pred_q;
    resolve = 1'b0;
    stall   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.br_valid && !bus.flush) begin
          if (bus.opnd_ready) begin
            resolve = 1'b1;
          end else begin
            stall   = 1'b1;
            state_d = WAIT;
            type_d  = bus.br_type;
            idx_d   = bus.br_pc[IDX+1:2];
            pred_d  = bus.br_pred;
          end
        end
      end
      WAIT: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else if (bus.opnd_ready) begin
          resolve = 1'b1;
          state_d = IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // While waiting, the latched branch identity overrides whatever ID presents now
  assign eff_type = (state_q == WAIT) ? type_q : bus.br_type;
  assign eff_idx  = (state_q == WAIT) ? idx_q  : bus.br_pc[IDX+1:2];
  assign eff_pred = (state_q == WAIT) ? pred_q : bus.br_pred;

  always_comb begin
    taken = 1'b0;
    case (eff_type)
      3'b000:  taken = (bus.opnd_a == bus.opnd_b);
      3'b001:  taken = (bus.opnd_a != bus.opnd_b);
      3'b010:  taken = bus.opnd_a[WIDTH-1] || (bus.opnd_a == '0);
      3'b011:  taken = !bus.opnd_a[WIDTH-1] && (bus.opnd_a != '0);
      3'b100:  taken = bus.opnd_a[WIDTH-1];
      3'b101:  taken = !bus.opnd_a[WIDTH-1];
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    bht_upd = bht_q[eff_idx];
    if (taken && bht_upd != 2'b11) begin
      bht_upd = bht_upd + 2'b01;
    end else if (!taken && bht_upd != 2'b00) begin
      bht_upd = bht_upd - 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      type_q       <= 3'b000;
      idx_q        <= '0;
      pred_q       <= 1'b0;
      res_valid_q  <= 1'b0;
      res_taken_q  <= 1'b0;
      mispredict_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      type_q       <= type_d;
      idx_q        <= idx_d;
      pred_q       <= pred_d;
      res_valid_q  <= resolve;
      res_taken_q  <= resolve && taken;
      mispredict_q <= resolve && (taken != eff_pred);
    end
  end

  // Statistics counters saturate instead of wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_count_q   <= '0;
      miss_count_q <= '0;
    end else if (resolve) begin
      if (br_count_q != '1) begin
        br_count_q <= br_count_q + 32'd1;
      end
      if ((taken != eff_pred) && miss_count_q != '1) begin
        miss_count_q <= miss_count_q + 32'd1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < BHT_DEPTH; gi++) begin : g_bht
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          bht_q[gi] <= 2'b01;
        end else if (resolve && eff_idx == IDX'(gi)) begin
          bht_q[gi] <= bht_upd;
        end
      end
    end
  endgenerate

  // Lookup reads the stored entry only: an update on the same edge is not bypassed
  assign lookup_idx     = bus.if_pc[IDX+1:2];
  assign bus.pred_taken = bht_q[lookup_idx][1];
  assign bus.br_stall   = stall;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_taken  = res_taken_q;
  assign bus.mispredict = mispredict_q;
  assign bus.br_count   = br_count_q;
  assign bus.miss_count = miss_count_q;

  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.br_pc, bus.if_pc};
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios plus randomized branches
// compared against a behavioural model of the conditions, counter table and statistics.
module tb_branch_resolve_unit;
  logic clk;
  logic rst_n;

  branch_resolve_unit_if #(.WIDTH(32)) bus ();

  branch_resolve_unit #(.WIDTH(32), .BHT_DEPTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Behavioural reference model
  int          bht_m [16];
  longint      br_m;
  longint      miss_m;
  logic        exp_taken;
  logic        exp_miss;
  logic        exp_pred;

  // Observations of the latest branch
  logic        obs_pred;
  int          obs_stall;
  logic        obs_rv;
  logic        obs_rt;
  logic        obs_miss;
  logic [31:0] obs_br;
  logic [31:0] obs_mc;
  logic        obs_rv2;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % 16);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) bht_m[i] = 1;
    br_m   = 0;
    miss_m = 0;
  endtask

  task automatic model_resolve(input logic [2:0] t, input logic [31:0] pc, input logic pred,
                               input logic [31:0] a, input logic [31:0] b);
    int sa;
    int k;
    sa = $signed(a);
    k  = idx_of(pc);
    case (t)
      3'd0:    exp_taken = (a == b);
      3'd1:    exp_taken = (a != b);
      3'd2:    exp_taken = (sa <= 0);
      3'd3:    exp_taken = (sa > 0);
      3'd4:    exp_taken = (sa < 0);
      3'd5:    exp_taken = (sa >= 0);
      default: exp_taken = 1'b0;
    endcase
    exp_miss = (exp_taken != pred);
    br_m   = (br_m   + 1 > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : br_m + 1;
    miss_m = (miss_m + (exp_miss ? 1 : 0) > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF
           : miss_m + (exp_miss ? 1 : 0);
    if (exp_taken) bht_m[k] = (bht_m[k] == 3) ? 3 : bht_m[k] + 1;
    else           bht_m[k] = (bht_m[k] == 0) ? 0 : bht_m[k] - 1;
  endtask

  task automatic idle_inputs();
    bus.br_valid   = 1'b0;
    bus.br_type    = 3'd0;
    bus.br_pc      = 32'h0;
    bus.br_pred    = 1'b0;
    bus.opnd_a     = 32'h0;
    bus.opnd_b     = 32'h0;
    bus.opnd_ready = 1'b0;
    bus.flush      = 1'b0;
    bus.if_pc      = 32'h0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Issue one branch whose operands become ready after n not-ready cycles; record outputs.
  task automatic run_branch(input logic [2:0] t, input logic [31:0] pc, input logic pred,
                            input logic [31:0] a, input logic [31:0] b, input int n);
    @(negedge clk);
    bus.if_pc      = pc;
    bus.br_valid   = 1'b1;
    bus.br_type    = t;
    bus.br_pc      = pc;
    bus.br_pred    = pred;
    bus.opnd_a     = a;
    bus.opnd_b     = b;
    bus.opnd_ready = (n == 0);
    bus.flush      = 1'b0;
    #1;
    obs_pred  = bus.pred_taken;
    obs_stall = bus.br_stall ? 1 : 0;
    exp_pred  = (bht_m[idx_of(pc)] >= 2);
    model_resolve(t, pc, pred, a, b);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      bus.br_type    = 3'($urandom_range(0, 7));
      bus.br_pc      = $urandom;
      bus.br_pred    = 1'($urandom_range(0, 1));
      bus.br_valid   = 1'($urandom_range(0, 1));
      bus.opnd_ready = (c == n - 1);
      #1;
      if (bus.br_stall) obs_stall++;
    end
    @(negedge clk);
    bus.br_valid   = 1'b0;
    bus.opnd_ready = 1'b0;
    #1;
    obs_rv  = bus.res_valid;
    obs_rt  = bus.res_taken;
    obs_miss = bus.mispredict;
    obs_br  = bus.br_count;
    obs_mc  = bus.miss_count;
    @(negedge clk);
    #1;
    obs_rv2 = bus.res_valid;
    $display("txn type=%0d pc=%h pred=%0b a=%h b=%h wait=%0d -> valid=%0b taken=%0b miss=%0b br=%0d mc=%0d",
             t, pc, pred, a, b, n, obs_rv, obs_rt, obs_miss, obs_br, obs_mc);
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got=%0b exp=0", bus.res_valid); end
    checks++; if (bus.res_taken !== 1'b0 || bus.mispredict !== 1'b0) begin errors++; $display("FAIL reset_taken_miss got=%0b%0b exp=00", bus.res_taken, bus.mispredict); end
    checks++; if (bus.br_count !== 32'h0 || bus.miss_count !== 32'h0) begin errors++; $display("FAIL reset_counts got=%h/%h exp=0/0", bus.br_count, bus.miss_count); end
    checks++; if (bus.br_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%0b exp=0", bus.br_stall); end
    for (int i = 0; i < 16; i++) begin
      bus.if_pc = 32'(i * 4);
      #1;
      checks++; if (bus.pred_taken !== 1'b0) begin errors++; $display("FAIL reset_pred idx=%0d got=%0b exp=0", i, bus.pred_taken); end
    end
  endtask

  task automatic test_basic();
    do_reset();
    run_branch(3'd0, 32'h1000, 1'b0, 32'h1234, 32'h1234, 0);
    checks++; if ({obs_rv, obs_rt, obs_miss} !== 3'b111) begin errors++; $display("FAIL beq_result got=%b exp=111", {obs_rv, obs_rt, obs_miss}); end
    checks++; if (obs_br !== 32'd1 || obs_mc !== 32'd1) begin errors++; $display("FAIL beq_counts got=%0d/%0d exp=1/1", obs_br, obs_mc); end
    checks++; if (obs_rv2 !== 1'b0) begin errors++; $display("FAIL beq_single_pulse got=%0b exp=0", obs_rv2); end
    bus.if_pc = 32'h1000;
    #1;
    checks++; if (bus.pred_taken !== 1'b1) begin errors++; $display("FAIL beq_entry_trained got=%0b exp=1", bus.pred_taken); end
    run_branch(3'd4, 32'h1004, 1'b1, 32'h8000_0000, 32'h0, 0);
    checks++; if ({obs_rv, obs_rt, obs_miss} !== 3'b110) begin errors++; $display("FAIL bltz_result got=%b exp=110", {obs_rv, obs_rt, obs_miss}); end
    run_branch(3'd3, 32'h1008, 1'b0, 32'h0, 32'h5, 0);
    checks++; if ({obs_rv, obs_rt, obs_miss} !== 3'b100) begin errors++; $display("FAIL bgtz_result got=%b exp=100", {obs_rv, obs_rt, obs_miss}); end
    run_branch(3'd2, 32'h100C, 1'b1, 32'h0, 32'h7, 0);
    checks++; if ({obs_rv, obs_rt, obs_miss} !== 3'b110) begin errors++; $display("FAIL blez_result got=%b exp=110", {obs_rv, obs_rt, obs_miss}); end
    checks++; if (obs_br !== 32'd4 || obs_mc !== 32'd1) begin errors++; $display("FAIL basic_counts got=%0d/%0d exp=4/1", obs_br, obs_mc); end
  endtask

  task automatic test_stall();
    run_branch(3'd1, 32'h2004, 1'b0, 32'h5, 32'h6, 3);
    checks++; if (obs_stall !== 3) begin errors++; $display("FAIL stall_len got=%0d exp=3", obs_stall); end
    checks++; if (obs_rv !== 1'b1 || obs_rt !== exp_taken || obs_miss !== exp_miss) begin errors++; $display("FAIL stall_result got=%0b%0b%0b exp=1%0b%0b", obs_rv, obs_rt, obs_miss, exp_taken, exp_miss); end
    checks++; if (obs_rv2 !== 1'b0) begin errors++; $display("FAIL stall_single_pulse got=%0b exp=0", obs_rv2); end
  endtask

  task automatic test_flush();
    int k;
    k = idx_of(32'h2000);
    @(negedge clk);
    bus.br_valid = 1'b1; bus.br_type = 3'd1; bus.br_pc = 32'h2000; bus.br_pred = 1'b0;
    bus.opnd_a = 32'h1; bus.opnd_b = 32'h2; bus.opnd_ready = 1'b0;
    @(negedge clk);
    bus.br_valid = 1'b0; bus.flush = 1'b1; bus.opnd_ready = 1'b1;
    #1;
    checks++; if (bus.br_stall !== 1'b0) begin errors++; $display("FAIL flush_stall got=%0b exp=0", bus.br_stall); end
    @(negedge clk);
    bus.flush = 1'b0; bus.opnd_ready = 1'b1; bus.if_pc = 32'h2000;
    #1;
    checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL flush_no_result got=%0b exp=0", bus.res_valid); end
    checks++; if (bus.br_count !== br_m[31:0] || bus.miss_count !== miss_m[31:0]) begin errors++; $display("FAIL flush_counts got=%0d/%0d exp=%0d/%0d", bus.br_count, bus.miss_count, br_m, miss_m); end
    checks++; if (bus.pred_taken !== (bht_m[k] >= 2)) begin errors++; $display("FAIL flush_table got=%0b exp=%0b", bus.pred_taken, bht_m[k] >= 2); end
    @(negedge clk);
    bus.opnd_ready = 1'b0;
    #1;
    checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL flush_left_wait got=%0b exp=0", bus.res_valid); end
    $display("txn flush during wait pc=00002000");
  endtask

  task automatic test_reset_mid_wait();
    run_branch(3'd0, 32'h2008, 1'b0, 32'h9, 32'h9, 0);
    @(negedge clk);
    bus.br_valid = 1'b1; bus.br_type = 3'd0; bus.br_pc = 32'h2008; bus.br_pred = 1'b0;
    bus.opnd_ready = 1'b0; bus.if_pc = 32'h2008;
    @(negedge clk);
    bus.br_valid = 1'b0;
    #1;
    checks++; if (bus.br_stall !== 1'b1) begin errors++; $display("FAIL wait_stall got=%0b exp=1", bus.br_stall); end
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.br_stall !== 1'b0 || bus.res_valid !== 1'b0) begin errors++; $display("FAIL rstmid_outputs got=%0b%0b exp=00", bus.br_stall, bus.res_valid); end
    checks++; if (bus.br_count !== 32'h0 || bus.miss_count !== 32'h0) begin errors++; $display("FAIL rstmid_counts got=%0d/%0d exp=0/0", bus.br_count, bus.miss_count); end
    checks++; if (bus.pred_taken !== 1'b0) begin errors++; $display("FAIL rstmid_table got=%0b exp=0", bus.pred_taken); end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    bus.opnd_ready = 1'b1;
    @(negedge clk);
    bus.opnd_ready = 1'b0;
    #1;
    checks++; if (bus.res_valid !== 1'b0 || bus.br_count !== 32'h0) begin errors++; $display("FAIL rstmid_abandoned got=%0b/%0d exp=0/0", bus.res_valid, bus.br_count); end
    $display("txn reset during wait pc=00002008");
  endtask

  task automatic test_pred_saturation();
    logic [3:0] preds;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      run_branch(3'd0, 32'h3000, 1'($urandom_range(0, 1)), 32'h42, 32'h42, 0);
      preds[i] = obs_pred;
      checks++; if (obs_pred !== exp_pred) begin errors++; $display("FAIL sat_pred_model i=%0d got=%0b exp=%0b", i, obs_pred, exp_pred); end
    end
    checks++; if (preds !== 4'b1110) begin errors++; $display("FAIL sat_pred_seq got=%b exp=1110", preds); end
    bus.if_pc = 32'h3040;
    #1;
    checks++; if (bus.pred_taken !== 1'b1) begin errors++; $display("FAIL alias_pred got=%0b exp=1", bus.pred_taken); end
  endtask

  task automatic test_back_to_back();
    logic p1, p2;
    int k;
    k = idx_of(32'h3100);
    @(negedge clk);
    bus.if_pc = 32'h3100; bus.br_valid = 1'b1; bus.br_type = 3'd1; bus.br_pc = 32'h3100;
    bus.br_pred = 1'b0; bus.opnd_a = 32'h1; bus.opnd_b = 32'h2; bus.opnd_ready = 1'b1;
    #1 p1 = bus.pred_taken;
    checks++; if (p1 !== (bht_m[k] >= 2)) begin errors++; $display("FAIL b2b_pred1 got=%0b exp=%0b", p1, bht_m[k] >= 2); end
    model_resolve(3'd1, 32'h3100, 1'b0, 32'h1, 32'h2);
    @(negedge clk);
    bus.br_pred = 1'b1; bus.opnd_a = 32'h3; bus.opnd_b = 32'h3;
    #1 p2 = bus.pred_taken;
    checks++; if (p2 !== (bht_m[k] >= 2)) begin errors++; $display("FAIL b2b_pred2 got=%0b exp=%0b", p2, bht_m[k] >= 2); end
    checks++; if (bus.res_valid !== 1'b1 || bus.res_taken !== 1'b1 || bus.mispredict !== 1'b1) begin errors++; $display("FAIL b2b_res1 got=%0b%0b%0b exp=111", bus.res_valid, bus.res_taken, bus.mispredict); end
    model_resolve(3'd1, 32'h3100, 1'b1, 32'h3, 32'h3);
    @(negedge clk);
    bus.br_valid = 1'b0; bus.opnd_ready = 1'b0;
    #1;
    checks++; if (bus.res_valid !== 1'b1 || bus.res_taken !== 1'b0 || bus.mispredict !== 1'b1) begin errors++; $display("FAIL b2b_res2 got=%0b%0b%0b exp=101", bus.res_valid, bus.res_taken, bus.mispredict); end
    checks++; if (bus.br_count !== br_m[31:0] || bus.miss_count !== miss_m[31:0]) begin errors++; $display("FAIL b2b_counts got=%0d/%0d exp=%0d/%0d", bus.br_count, bus.miss_count, br_m, miss_m); end
    @(negedge clk);
    #1;
    checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL b2b_pulse_end got=%0b exp=0", bus.res_valid); end
    $display("txn back-to-back bne pc=00003100 pred1=%0b pred2=%0b", p1, p2);
  endtask

  task automatic test_random();
    logic [2:0]  t;
    logic [31:0] pc, a, b;
    logic        pred;
    int          n;
    for (int i = 0; i < 40; i++) begin
      t    = 3'($urandom_range(0, 7));
      pc   = {$urandom_range(0, 255), 2'b00};
      pred = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       a = 32'h0;
        1:       a = 32'h8000_0000 | $urandom;
        default: a = $urandom_range(0, 3);
      endcase
      b = ($urandom_range(0, 1) != 0) ? a : $urandom_range(0, 3);
      n = $urandom_range(0, 3);
      run_branch(t, pc, pred, a, b, n);
      checks++; if (obs_pred !== exp_pred) begin errors++; $display("FAIL rnd_pred i=%0d got=%0b exp=%0b", i, obs_pred, exp_pred); end
      checks++; if (obs_stall !== n) begin errors++; $display("FAIL rnd_stall i=%0d got=%0d exp=%0d", i, obs_stall, n); end
      checks++; if (obs_rv !== 1'b1 || obs_rv2 !== 1'b0) begin errors++; $display("FAIL rnd_valid i=%0d got=%0b%0b exp=10", i, obs_rv, obs_rv2); end
      checks++; if (obs_rt !== exp_taken || obs_miss !== exp_miss) begin errors++; $display("FAIL rnd_result i=%0d got=%0b%0b exp=%0b%0b", i, obs_rt, obs_miss, exp_taken, exp_miss); end
      checks++; if (obs_br !== br_m[31:0] || obs_mc !== miss_m[31:0]) begin errors++; $display("FAIL rnd_counts i=%0d got=%0d/%0d exp=%0d/%0d", i, obs_br, obs_mc, br_m, miss_m); end
    end
  endtask

  task automatic test_count_saturation();
    @(negedge clk);
    force dut.br_count_q = 32'hFFFF_FFFE;
    #1;
    release dut.br_count_q;
    br_m = 64'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) begin
      run_branch(3'd5, 32'h4000, 1'b1, 32'h1, 32'h0, 0);
      checks++; if (obs_br !== 32'hFFFF_FFFF) begin errors++; $display("FAIL count_sat i=%0d got=%h exp=ffffffff", i, obs_br); end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_basic();
    test_stall();
    test_flush();
    test_reset_mid_wait();
    test_pred_saturation();
    test_back_to_back();
    test_random();
    test_count_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
